// File: rtl/clb_cfg_pkg.sv
// Shared types and sizing helpers for the CLB configuration loader.
package clb_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_SCAN_FETCH = 4'd1,
    ST_SCAN_SHIFT = 4'd2,
    ST_LUT_WE     = 4'd3,
    ST_NEMS_FETCH = 4'd4,
    ST_NEMS_HOLD  = 4'd5,
    ST_NEMS_GAP   = 4'd6,
    ST_DONE       = 4'd7,
    ST_ERR        = 4'd8
  } cfg_state_t;

  localparam int DEF_NEMS_ROWS = 30;
  localparam int DEF_NEMS_COLS = 29;

  // Number of 32-bit host words needed to cover the scan chain.
  function automatic int calc_sw(input int chain_len);
    return (chain_len + 31) / 32;
  endfunction

endpackage

// File: rtl/cfg_piso32.sv
// 32-bit parallel-in serial-out register feeding the tile scan chain, LSB first.
module cfg_piso32 (
  input  logic        cfg_clk,
  input  logic        cfg_rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic        shift,
  input  logic [31:0] d,
  output logic        q_lsb
);

  logic [31:0] sr;

  always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
    if (!cfg_rst_n)  sr <= '0;
    else if (clr)    sr <= '0;
    else if (load)   sr <= d;
    else if (shift)  sr <= {1'b0, sr[31:1]};
  end

  assign q_lsb = sr[0];

endmodule

// File: rtl/clb_cfg_loader.sv
// Configuration sequencer: scan-chain load, LUT commit, then timed NEMS relay programming.
module clb_cfg_loader
  import clb_cfg_pkg::*;
#(
  parameter int CHAIN_LEN   = 1024,
  parameter int NEMS_ROWS   = DEF_NEMS_ROWS,
  parameter int NEMS_COLS   = DEF_NEMS_COLS,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                 cfg_clk,
  input  logic                 cfg_rst_n,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [31:0]          s_data,
  input  logic                 s_last,
  output logic                 cfg_scan_en,
  output logic                 cfg_scan_in,
  output logic                 cfg_lut_we,
  input  logic                 cfg_scan_out,
  output logic [NEMS_ROWS-1:0] cfgrows,
  output logic [NEMS_COLS-1:0] cfgcols,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 crc_par,
  output logic [3:0]           dbg_state
);

  localparam int BCW = $clog2(calc_sw(CHAIN_LEN) * 32 + 1);
  localparam int CCW = $clog2(NEMS_COLS + 1);
  localparam int HCW = $clog2(HOLD_CYCLES + 1);
  localparam logic [BCW-1:0]       BIT_LAST  = BCW'(CHAIN_LEN - 1);
  localparam logic [CCW-1:0]       COL_LAST  = CCW'(NEMS_COLS - 1);
  localparam logic [HCW-1:0]       HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [NEMS_COLS-1:0] COL_ONE   = NEMS_COLS'(1);

  cfg_state_t     state;
  logic [BCW-1:0] bit_cnt;
  logic [4:0]     bit_idx;
  logic [CCW-1:0] col;
  logic [HCW-1:0] hold_cnt;
  logic           hs, scan_last, word_last;
  logic           piso_clr, piso_load, piso_shift;

  // Handshake: a word transfers on a rising edge where s_valid && s_ready.
  // s_ready is a pure state decode; the host must hold s_data/s_last while s_valid waits.
  assign s_ready   = (state == ST_SCAN_FETCH) || (state == ST_NEMS_FETCH);
  assign hs        = s_valid && s_ready;
  assign dbg_state = state;

  assign scan_last  = (bit_cnt == BIT_LAST);
  assign word_last  = (bit_idx == 5'd31);
  assign piso_load  = (state == ST_SCAN_FETCH) && hs && !s_last;
  assign piso_shift = (state == ST_SCAN_SHIFT);
  // Clearing on the last shift keeps cfg_scan_in low whenever scanning is idle.
  assign piso_clr   = (state == ST_SCAN_SHIFT) && (scan_last || word_last);

  cfg_piso32 u_piso (
    .cfg_clk   (cfg_clk),
    .cfg_rst_n (cfg_rst_n),
    .clr       (piso_clr),
    .load      (piso_load),
    .shift     (piso_shift),
    .d         (s_data),
    .q_lsb     (cfg_scan_in)
  );

  always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
    if (!cfg_rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      col         <= '0;
      hold_cnt    <= '0;
      cfg_scan_en <= 1'b0;
      cfg_lut_we  <= 1'b0;
      cfgrows     <= '0;
      cfgcols     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      crc_par     <= 1'b0;
    end else begin
      done       <= 1'b0;
      cfg_lut_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state   <= ST_SCAN_FETCH;
            busy    <= 1'b1;
            err     <= 1'b0;
            crc_par <= 1'b0;
            bit_cnt <= '0;
            bit_idx <= '0;
            col     <= '0;
          end
        end
        ST_SCAN_FETCH: begin
          if (hs) begin
            if (s_last) begin
              state <= ST_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state       <= ST_SCAN_SHIFT;
              cfg_scan_en <= 1'b1;
              bit_idx     <= '0;
            end
          end
        end
        ST_SCAN_SHIFT: begin
          crc_par <= crc_par ^ cfg_scan_out;
          bit_cnt <= bit_cnt + 1'b1;
          bit_idx <= bit_idx + 1'b1;
          if (scan_last) begin
            state       <= ST_LUT_WE;
            cfg_scan_en <= 1'b0;
            cfg_lut_we  <= 1'b1;
          end else if (word_last) begin
            state       <= ST_SCAN_FETCH;
            cfg_scan_en <= 1'b0;
          end
        end
        ST_LUT_WE: state <= ST_NEMS_FETCH;
        ST_NEMS_FETCH: begin
          if (hs) begin
            // The last flag must land exactly on the final column's mask.
            if (s_last != (col == COL_LAST)) begin
              state <= ST_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= ST_NEMS_HOLD;
              cfgrows  <= s_data[NEMS_ROWS-1:0];
              cfgcols  <= COL_ONE << col;
              hold_cnt <= '0;
            end
          end
        end
        ST_NEMS_HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state   <= ST_NEMS_GAP;
            cfgrows <= '0;
            cfgcols <= '0;
          end
        end
        ST_NEMS_GAP: begin
          if (col == COL_LAST) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            col   <= col + 1'b1;
            state <= ST_NEMS_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Self-checking bench for clb_cfg_loader: scan and relay-pulse scoreboards plus scenario tasks.
module tb_clb_cfg_loader;
  import clb_cfg_pkg::*;

  localparam int CHAIN_LEN   = 40;
  localparam int NEMS_ROWS   = 30;
  localparam int NEMS_COLS   = 29;
  localparam int HOLD_CYCLES = 4;
  localparam int SW          = (CHAIN_LEN + 31) / 32;
  localparam int LOAD_LAT    = SW + CHAIN_LEN + 1 + NEMS_COLS * (HOLD_CYCLES + 2) + 1;
  localparam int PW          = NEMS_COLS + NEMS_ROWS;

  logic                 cfg_clk, cfg_rst_n, start, s_valid, s_ready, s_last;
  logic [31:0]          s_data;
  logic                 cfg_scan_en, cfg_scan_in, cfg_lut_we, cfg_scan_out;
  logic [NEMS_ROWS-1:0] cfgrows;
  logic [NEMS_COLS-1:0] cfgcols;
  logic                 busy, done, err, crc_par;
  logic [3:0]           dbg_state;

  clb_cfg_loader #(
    .CHAIN_LEN(CHAIN_LEN), .NEMS_ROWS(NEMS_ROWS),
    .NEMS_COLS(NEMS_COLS), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .cfg_clk(cfg_clk), .cfg_rst_n(cfg_rst_n), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .cfg_scan_en(cfg_scan_en), .cfg_scan_in(cfg_scan_in), .cfg_lut_we(cfg_lut_we),
    .cfg_scan_out(cfg_scan_out), .cfgrows(cfgrows), .cfgcols(cfgcols),
    .busy(busy), .done(done), .err(err), .crc_par(crc_par), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial cfg_clk = 1'b0;
  always #5 cfg_clk = ~cfg_clk;

  int cyc = 0;
  always @(posedge cfg_clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard state
  logic          exp_scan_q[$];
  logic [PW-1:0] exp_pulse_q[$];
  logic [PW-1:0] cur_pulse;
  logic          exp_crc;
  bit            mon_on = 0;
  int            scan_cnt, lut_cnt, pulse_cnt, col5_cycles, run_len, done_cnt;
  int            start_cyc, done_cyc;

  localparam logic [NEMS_COLS-1:0] COL5  = NEMS_COLS'(1) << 5;
  localparam logic [NEMS_ROWS-1:0] MASK5 = 30'h2AAAAAAA;

  always @(negedge cfg_clk) begin
    cfg_scan_out = 1'($urandom_range(0, 1));
    if (cfg_scan_en) exp_crc ^= cfg_scan_out;
    if (start && !busy) start_cyc = cyc;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (mon_on) begin
      if (cfg_lut_we) lut_cnt++;
      if (cfg_scan_en) begin
        scan_cnt++;
        n_checks++;
        if (dbg_state !== ST_SCAN_SHIFT) begin
          n_fail++; $display("FAIL scan_en_state: scan_en high in state %0d, required %0d", dbg_state, ST_SCAN_SHIFT);
        end
        n_checks++;
        if (exp_scan_q.size() == 0) begin
          n_fail++; $display("FAIL scan_extra: bit %0b emitted, required no further bits", cfg_scan_in);
        end else begin
          logic eb;
          eb = exp_scan_q.pop_front();
          if (cfg_scan_in !== eb) begin
            n_fail++; $display("FAIL scan_bit: got %0b, required %0b (bit %0d)", cfg_scan_in, eb, scan_cnt - 1);
          end
        end
      end
      n_checks++;
      if (cfgrows != '0 && cfgcols == '0) begin
        n_fail++; $display("FAIL rows_no_col: cfgrows=%h with cfgcols=0, required 0", cfgrows);
      end
      n_checks++;
      if ($countones(cfgcols) > 1) begin
        n_fail++; $display("FAIL cols_onehot: cfgcols=%h, required at most one bit", cfgcols);
      end
      if (cfgcols != '0) begin
        if (run_len == 0) begin
          if (exp_pulse_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL pulse_extra: cols=%h rows=%h, required no pulse", cfgcols, cfgrows);
            cur_pulse = '0;
          end else cur_pulse = exp_pulse_q.pop_front();
        end
        run_len++;
        n_checks++;
        if ({cfgcols, cfgrows} !== cur_pulse) begin
          n_fail++; $display("FAIL pulse_value: cols/rows=%h, required %h", {cfgcols, cfgrows}, cur_pulse);
        end
        if (cfgcols == COL5 && cfgrows == MASK5) col5_cycles++;
      end else if (run_len != 0) begin
        n_checks++;
        if (run_len != HOLD_CYCLES) begin
          n_fail++; $display("FAIL pulse_len: %0d cycles, required %0d", run_len, HOLD_CYCLES);
        end
        pulse_cnt++;
        run_len = 0;
      end
    end
  end

  // Driver tasks: all entered and left at posedge+1.
  task automatic send_word(input logic [31:0] data, input logic last, input int bp_max, output bit ok);
    int waited;
    ok = 0;
    repeat ($urandom_range(0, bp_max)) begin @(posedge cfg_clk); #1; end
    s_valid = 1'b1; s_data = data; s_last = last;
    waited = 0;
    while (!ok && waited < 300) begin
      @(negedge cfg_clk);
      if (s_ready) ok = 1;
      @(posedge cfg_clk); #1;
      waited++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_timeout: no s_ready within %0d cycles, required handshake", waited);
    end
  endtask

  task automatic send_load(input int bp_max, input int early_word, input bit drop_last,
                           input int n_masks, output bit ok);
    logic [31:0]          data;
    logic                 last;
    logic [NEMS_COLS-1:0] one_c;
    one_c = 1;
    ok = 1;
    for (int w = 0; w < SW; w++) begin
      data = $urandom();
      last = (w == early_word);
      if (!last)
        for (int k = 0; k < 32; k++) if (w * 32 + k < CHAIN_LEN) exp_scan_q.push_back(data[k]);
      send_word(data, last, bp_max, ok);
      if (!ok || last) return;
    end
    for (int c = 0; c < n_masks; c++) begin
      data = (c == 5) ? 32'h2AAAAAAA : $urandom();
      last = (c == NEMS_COLS - 1) && !drop_last;
      if (!(drop_last && c == NEMS_COLS - 1))
        exp_pulse_q.push_back({one_c << c, data[NEMS_ROWS-1:0]});
      send_word(data, last, bp_max, ok);
      if (!ok) return;
    end
  endtask

  task automatic do_start();
    @(posedge cfg_clk); #1; start = 1'b1;
    @(posedge cfg_clk); #1; start = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge cfg_clk); cfg_rst_n = 1'b0; s_valid = 1'b0; start = 1'b0;
    @(negedge cfg_clk); cfg_rst_n = 1'b1;
  endtask

  task automatic clear_sb();
    exp_scan_q.delete(); exp_pulse_q.delete();
    scan_cnt = 0; lut_cnt = 0; pulse_cnt = 0; col5_cycles = 0; run_len = 0; exp_crc = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 0;
    for (int i = 0; i < 800 && !ok; i++) begin
      @(negedge cfg_clk); #1;
      if (done_cnt > base) ok = 1;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL done_timeout: done not seen, required a done pulse"); end
  endtask

  task automatic check_load_end(input string tag);
    n_checks++;
    if (scan_cnt != CHAIN_LEN) begin n_fail++; $display("FAIL %s_scan_cnt: %0d, required %0d", tag, scan_cnt, CHAIN_LEN); end
    n_checks++;
    if (exp_scan_q.size() != 0) begin n_fail++; $display("FAIL %s_scan_left: %0d bits unshifted, required 0", tag, exp_scan_q.size()); end
    n_checks++;
    if (lut_cnt != 1) begin n_fail++; $display("FAIL %s_lut_we: %0d strobes, required 1", tag, lut_cnt); end
    n_checks++;
    if (pulse_cnt != NEMS_COLS) begin n_fail++; $display("FAIL %s_pulses: %0d, required %0d", tag, pulse_cnt, NEMS_COLS); end
    n_checks++;
    if (col5_cycles != HOLD_CYCLES) begin n_fail++; $display("FAIL %s_col5_mask: %0d cycles, required %0d", tag, col5_cycles, HOLD_CYCLES); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL %s_err: %0b, required 0", tag, err); end
    n_checks++;
    if (crc_par !== exp_crc) begin n_fail++; $display("FAIL %s_crc: %0b, required %0b", tag, crc_par, exp_crc); end
    n_checks++;
    if (busy !== 1'b0 || dbg_state !== ST_DONE) begin
      n_fail++; $display("FAIL %s_end_state: busy=%0b state=%0d, required 0/%0d", tag, busy, dbg_state, ST_DONE);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    cfg_rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    #23;
    n_checks++;
    if ({cfg_scan_en, cfg_scan_in, cfg_lut_we, busy, done, err, crc_par, s_ready} !== 8'd0) begin
      n_fail++; $display("FAIL reset_flags: %b, required 00000000", {cfg_scan_en, cfg_scan_in, cfg_lut_we, busy, done, err, crc_par, s_ready});
    end
    n_checks++;
    if (cfgrows !== '0 || cfgcols !== '0) begin n_fail++; $display("FAIL reset_relays: rows=%h cols=%h, required 0", cfgrows, cfgcols); end
    @(negedge cfg_clk); cfg_rst_n = 1'b1;
    @(posedge cfg_clk); #1; s_valid = 1'b1; s_data = 32'hFFFF_FFFF;
    repeat (3) @(negedge cfg_clk);
    n_checks++;
    if (dbg_state !== ST_IDLE || s_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_valid: state=%0d s_ready=%0b, required %0d/0", dbg_state, s_ready, ST_IDLE);
    end
    @(posedge cfg_clk); #1; s_valid = 1'b0;
  endtask

  task automatic test_nominal();
    bit ok;
    int base;
    clear_sb(); mon_on = 1; base = done_cnt;
    do_start();
    send_load(0, -1, 0, NEMS_COLS, ok);
    wait_done(base, ok);
    n_checks++;
    if (done_cyc - start_cyc != LOAD_LAT) begin
      n_fail++; $display("FAIL nominal_latency: %0d cycles, required %0d", done_cyc - start_cyc, LOAD_LAT);
    end
    check_load_end("nominal");
    @(negedge cfg_clk); #1;
    n_checks++;
    if (done !== 1'b0 || dbg_state !== ST_DONE) begin
      n_fail++; $display("FAIL done_one_cycle: done=%0b state=%0d, required 0/%0d", done, dbg_state, ST_DONE);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int base;
    clear_sb(); base = done_cnt;
    do_start();
    send_load(3, -1, 0, NEMS_COLS, ok);
    wait_done(base, ok);
    n_checks++;
    if (done_cyc - start_cyc < LOAD_LAT) begin
      n_fail++; $display("FAIL bp_latency: %0d cycles, required at least %0d", done_cyc - start_cyc, LOAD_LAT);
    end
    check_load_end("bp");
  endtask

  task automatic test_early_last();
    bit ok;
    clear_sb();
    do_start();
    send_load(0, 1, 0, 0, ok);
    @(negedge cfg_clk); #1;
    n_checks++;
    if (dbg_state !== ST_ERR || err !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL early_last_err: state=%0d err=%0b ready=%0b busy=%0b, required %0d/1/0/0", dbg_state, err, s_ready, busy, ST_ERR);
    end
    repeat (5) @(negedge cfg_clk);
    n_checks++;
    if (err !== 1'b1 || lut_cnt != 0) begin n_fail++; $display("FAIL early_last_sticky: err=%0b lut_we=%0d, required 1/0", err, lut_cnt); end
    n_checks++;
    if (exp_scan_q.size() != 0) begin n_fail++; $display("FAIL early_last_scan: %0d bits unshifted, required 0", exp_scan_q.size()); end
    do_start();
    @(negedge cfg_clk); #1;
    n_checks++;
    if (err !== 1'b0 || dbg_state !== ST_SCAN_FETCH) begin
      n_fail++; $display("FAIL start_clears_err: err=%0b state=%0d, required 0/%0d", err, dbg_state, ST_SCAN_FETCH);
    end
    apply_reset();
  endtask

  task automatic test_missing_last();
    bit ok;
    int base;
    clear_sb(); base = done_cnt;
    do_start();
    send_load(0, -1, 1, NEMS_COLS, ok);
    @(negedge cfg_clk); #1;
    n_checks++;
    if (dbg_state !== ST_ERR || err !== 1'b1) begin
      n_fail++; $display("FAIL missing_last_err: state=%0d err=%0b, required %0d/1", dbg_state, err, ST_ERR);
    end
    repeat (20) @(negedge cfg_clk);
    n_checks++;
    if (done_cnt != base || err !== 1'b1) begin
      n_fail++; $display("FAIL missing_last_done: done pulses=%0d err=%0b, required 0/1", done_cnt - base, err);
    end
    n_checks++;
    if (pulse_cnt != NEMS_COLS - 1 || cfgcols !== '0) begin
      n_fail++; $display("FAIL missing_last_pulses: %0d cols=%h, required %0d/0", pulse_cnt, cfgcols, NEMS_COLS - 1);
    end
  endtask

  task automatic test_mid_hold_reset();
    bit ok;
    bit seen;
    logic [NEMS_COLS-1:0] col2;
    col2 = NEMS_COLS'(1) << 2;
    mon_on = 0; clear_sb();
    do_start();
    send_load(0, -1, 0, 3, ok);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge cfg_clk);
      if (cfgcols == col2) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL hold_reach: col 2 pulse not seen, required cfgcols=%h", col2); end
    do_start();
    @(negedge cfg_clk); #1;
    n_checks++;
    if (dbg_state !== ST_NEMS_HOLD || cfgcols !== col2) begin
      n_fail++; $display("FAIL start_while_busy: state=%0d cols=%h, required %0d/%h", dbg_state, cfgcols, ST_NEMS_HOLD, col2);
    end
    #1; cfg_rst_n = 1'b0;
    #1;
    n_checks++;
    if (cfgrows !== '0 || cfgcols !== '0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL async_reset: rows=%h cols=%h busy=%0b state=%0d, required 0/0/0/%0d", cfgrows, cfgcols, busy, dbg_state, ST_IDLE);
    end
    @(negedge cfg_clk); cfg_rst_n = 1'b1;
    repeat (2) @(negedge cfg_clk);
    n_checks++;
    if (dbg_state !== ST_IDLE || cfgrows !== '0 || cfgcols !== '0) begin
      n_fail++; $display("FAIL post_reset_idle: state=%0d rows=%h cols=%h, required %0d/0/0", dbg_state, cfgrows, cfgcols, ST_IDLE);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_scan_out = 1'b0;
    done_cnt = 0; start_cyc = 0; done_cyc = 0;
    clear_sb();
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_mid_hold_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
